vga_fb_display: RTL and testbench
=================================

Name: vga_fb_display

Overview:
Parametrised VGA framebuffer display engine with an Avalon-MM slave for CPU access. Owns the VGA timing counters, a double-buffered on-chip pixel store, and a hardware fill engine. The CPU draws into the back buffer through an auto-incrementing pixel port. The buffers swap atomically at the start of vertical blanking. Sits between the HPS lightweight bridge and the VGA DAC pins.

Parameters:
HACTIVE, 640, visible pixels per line
VACTIVE, 480, visible lines per frame
HFP, 16 / HSW, 96 / HBP, 48, horizontal porch and sync widths in pixels
VFP, 10 / VSW, 2 / VBP, 33, vertical porch and sync widths in lines
PIX_W, 8, bits per stored pixel (grey level; 1..8)
AW, 19, pixel address width; must satisfy 2^AW >= HACTIVE*VACTIVE

Ports:
clk  in  1  50 MHz system clock
reset  in  1  asynchronous, active-high
chipselect  in  1  Avalon select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
address  in  3  register index
writedata  in  16  write data
readdata  out  16  registered read data
VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
VGA_CLK  out  1  25 MHz pixel clock (hcount[0])
VGA_HS, VGA_VS  out  1  syncs, active-low
VGA_BLANK_n  out  1  active-video flag
VGA_SYNC_n  out  1  tied 0

Behaviour:
- Clock and reset: reset, asynchronous, active-high; clock clk.
- Register map (write):
  - 0 XPTR: bits [10:0] set the x pointer.
  - 1 YPTR: bits [9:0] set the y pointer.
  - 2 PIXEL: writes writedata[PIX_W-1:0] to the back buffer at y*HACTIVE+x. Then x++. If x reaches HACTIVE, x=0 and y++. If y reaches VACTIVE, y=0.
  - 3 CTRL: bit0=1 requests swap (sets swap_pend). bit1=1 starts fill (ignored if fill busy).
  - 4 FILLC: fill colour.
- Register map (read):
  - 5 STATUS: bit0 swap_pend, bit1 fill_busy, bit2 front buffer index.
  - 6 FRAME: 16-bit frame counter, wraps at 0xFFFF->0.
  - Other addresses read 0; writes to them are ignored.
- readdata latency is 1 clk after read&chipselect.
- XPTR/YPTR values >= HACTIVE/VACTIVE are clamped to HACTIVE-1/VACTIVE-1.
- Timing:
  - hcount runs 0..2*(HACTIVE+HFP+HSW+HBP)-1; pixel column = hcount[10:1].
  - vcount runs 0..VACTIVE+VFP+VSW+VBP-1 and increments at end of line.
  - HS low for HSW pixels after HACTIVE+HFP. VS low for VSW lines after VACTIVE+VFP.
- Pixel path:
  - Read address = vcount*HACTIVE + col into the front buffer.
  - Synchronous RAM (1 clk) plus output register (1 clk) gives a 2-clk pipeline.
  - HS, VS and BLANK_n are delayed by 2 clk so they align with the pixel data.
  - RGB = pixel left-justified to 8 bits, replicated on R, G and B.
  - RGB = 0 whenever the delayed BLANK_n is 0.
- Swap:
  - On the first clk where vcount==VACTIVE and hcount==0, if swap_pend and !fill_busy: toggle the front index, clear swap_pend, FRAME++.
  - A swap request while fill is busy stays pending until the first vblank start after the fill completes.
  - A second request while pending has no extra effect.
- Fill FSM: IDLE -> FILL -> IDLE.
  - FILL writes FILLC to back-buffer addresses 0..HACTIVE*VACTIVE-1, one per clk.
  - Returns to IDLE after the last address; fill_busy=0 from that next clk.
- Write port arbitration: a CPU PIXEL write has priority over the fill engine. Fill stalls that cycle, without skipping an address.
- A swap never occurs mid-fill, so the fill always targets one buffer.
- Reset values:
  - hcount=vcount=0, x=y=0, FILLC=0, front=0, swap_pend=0, FSM=IDLE, FRAME=0.
  - readdata=0, RGB=0, delayed BLANK_n=0, delayed HS/VS=1.
  - RAM contents are undefined.
- Reset asserted mid-fill aborts the fill immediately.

Test Plan:
- Reset, then free-run: HS period 1600 clk, low for 192 clk. VS period 525 lines, low for 2 lines. RGB=0 throughout blanking.
- XPTR=638, YPTR=5, three PIXEL writes 0x11,0x22,0x33 -> they land at (638,5), (639,5), (0,6). A later x pointer write of 700 reads back as 639 on the next pixel write location.
- FILLC=0x80, CTRL=0x2, CTRL=0x1 -> STATUS=0x3 during the fill. The swap happens at the first vblank after 307200 fill cycles. The next frame shows VGA_R=G=B=0x80 on all active pixels, and FRAME increments by 1.
- PIXEL writes issued every other clk during a fill -> the fill finishes exactly N clk later than the no-writes case, where N = number of PIXEL writes. A PIXEL write to an address the fill has not yet reached is overwritten by the fill; one to an address already filled persists.
- Write (10,0)=0xFF into the back buffer, then swap -> the first active line shows 0xFF exactly at column 10. HS/VS/BLANK_n edges are aligned to the pixel data (2-clk pipeline check).
- Assert reset during a fill -> STATUS=0 and RGB=0 while reset is held. Timing restarts from hcount=vcount=0 after release.

Source files
------------

// File: rtl/vga_fb_display_if.sv
// Avalon-MM register window of the VGA framebuffer display engine.
interface vga_fb_display_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [2:0]  address;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (output chipselect, write, read, address, writedata, input readdata);
  modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/vga_fb_display.sv
// VGA timing, double-buffered pixel store with CPU pixel port and hardware fill,
// buffer swap at start of vertical blanking.
module vga_fb_display #(
  parameter int HACTIVE = 640,
  parameter int VACTIVE = 480,
  parameter int HFP     = 16,
  parameter int HSW     = 96,
  parameter int HBP     = 48,
  parameter int VFP     = 10,
  parameter int VSW     = 2,
  parameter int VBP     = 33,
  parameter int PIX_W   = 8,
  parameter int AW      = 19
) (
  input  logic             clk,
  input  logic             reset,
  vga_fb_display_if.slave  avs,
  output logic [7:0]       VGA_R,
  output logic [7:0]       VGA_G,
  output logic [7:0]       VGA_B,
  output logic             VGA_CLK,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK_n,
  output logic             VGA_SYNC_n
);
  localparam int HTOT  = HACTIVE + HFP + HSW + HBP;
  localparam int VTOT  = VACTIVE + VFP + VSW + VBP;
  localparam int DEPTH = 2 ** AW;

  localparam logic [10:0]   H_LAST   = 11'(2 * HTOT - 1);
  localparam logic [9:0]    H_ACT    = 10'(HACTIVE);
  localparam logic [9:0]    HS_BEG   = 10'(HACTIVE + HFP);
  localparam logic [9:0]    HS_END   = 10'(HACTIVE + HFP + HSW);
  localparam logic [9:0]    V_ACT    = 10'(VACTIVE);
  localparam logic [9:0]    VS_BEG   = 10'(VACTIVE + VFP);
  localparam logic [9:0]    VS_END   = 10'(VACTIVE + VFP + VSW);
  localparam logic [9:0]    V_LAST   = 10'(VTOT - 1);
  localparam logic [10:0]   X_MAX    = 11'(HACTIVE - 1);
  localparam logic [9:0]    Y_MAX    = 10'(VACTIVE - 1);
  localparam logic [AW-1:0] LINE_LEN = AW'(HACTIVE);
  localparam logic [AW-1:0] PIX_LAST = AW'(HACTIVE * VACTIVE - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  function automatic logic [10:0] clamp_x(input logic [10:0] v);
    return (v > X_MAX) ? X_MAX : v;
  endfunction

  function automatic logic [9:0] clamp_y(input logic [9:0] v);
    return (v > Y_MAX) ? Y_MAX : v;
  endfunction

  // Grey level left-justified into the 8-bit DAC word.
  function automatic logic [7:0] widen(input logic [PIX_W-1:0] p);
    logic [7:0] r;
    r = '0;
    r[7 -: PIX_W] = p;
    return r;
  endfunction

  logic [10:0]      hcount;
  logic [9:0]       vcount;
  logic [9:0]       col;
  logic [10:0]      x_ptr;
  logic [9:0]       y_ptr;
  logic [PIX_W-1:0] fill_color;
  logic             front;
  logic             swap_pend;
  logic [0:0]       state;
  logic [AW-1:0]    fill_addr;
  logic [15:0]      frame_cnt;

  logic             wr_en, rd_en, pix_wr, ctrl_wr;
  logic             fill_busy, fill_we, swap_now;
  logic [AW-1:0]    pix_addr;
  logic             mem_we;
  logic [AW-1:0]    waddr;
  logic [PIX_W-1:0] wdata;
  logic             unused_wd;

  assign col       = hcount[10:1];
  assign wr_en     = avs.chipselect & avs.write;
  assign rd_en     = avs.chipselect & avs.read;
  assign pix_wr    = wr_en && (avs.address == 3'd2);
  assign ctrl_wr   = wr_en && (avs.address == 3'd3);
  assign fill_busy = (state == S_FILL);
  assign fill_we   = fill_busy & ~pix_wr;
  assign swap_now  = (vcount == V_ACT) && (hcount == 11'd0) && swap_pend && !fill_busy;
  assign pix_addr  = AW'(y_ptr) * LINE_LEN + AW'(x_ptr);
  assign unused_wd = ^avs.writedata[15:11];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 11'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_ptr      <= '0;
      y_ptr      <= '0;
      fill_color <= '0;
    end else if (wr_en) begin
      case (avs.address)
        3'd0: x_ptr <= clamp_x(avs.writedata[10:0]);
        3'd1: y_ptr <= clamp_y(avs.writedata[9:0]);
        3'd2: begin
          if (x_ptr >= X_MAX) begin
            x_ptr <= '0;
            y_ptr <= (y_ptr >= Y_MAX) ? 10'd0 : y_ptr + 10'd1;
          end else begin
            x_ptr <= x_ptr + 11'd1;
          end
        end
        3'd4: fill_color <= avs.writedata[PIX_W-1:0];
        default: ;
      endcase
    end
  end

  // Swap is held off while filling, so a fill never straddles two buffers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      front     <= 1'b0;
      swap_pend <= 1'b0;
      frame_cnt <= '0;
      state     <= S_IDLE;
      fill_addr <= '0;
    end else begin
      if (swap_now) begin
        front     <= ~front;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (ctrl_wr && avs.writedata[0])
        swap_pend <= 1'b1;
      else if (swap_now)
        swap_pend <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ctrl_wr && avs.writedata[1]) begin
            state     <= S_FILL;
            fill_addr <= '0;
          end
        end
        default: begin
          if (fill_we) begin
            if (fill_addr == PIX_LAST) state <= S_IDLE;
            else                       fill_addr <= fill_addr + AW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      avs.readdata <= '0;
    else if (rd_en) begin
      case (avs.address)
        3'd5:    avs.readdata <= {13'd0, front, fill_busy, swap_pend};
        3'd6:    avs.readdata <= frame_cnt;
        default: avs.readdata <= '0;
      endcase
    end
  end

  // CPU pixel writes win the shared write port; the fill simply waits a cycle.
  logic [PIX_W-1:0] fb0 [DEPTH];
  logic [PIX_W-1:0] fb1 [DEPTH];

  assign mem_we = pix_wr | fill_we;
  assign waddr  = pix_wr ? pix_addr : fill_addr;
  assign wdata  = pix_wr ? avs.writedata[PIX_W-1:0] : fill_color;

  always_ff @(posedge clk) begin
    if (mem_we && front)  fb0[waddr] <= wdata;
    if (mem_we && !front) fb1[waddr] <= wdata;
  end

  // stage p0: scan position decode
  logic          active_p0, hs_p0, vs_p0;
  logic [AW-1:0] raddr_p0;

  assign active_p0 = (col < H_ACT) && (vcount < V_ACT);
  assign hs_p0     = !((col >= HS_BEG) && (col < HS_END));
  assign vs_p0     = !((vcount >= VS_BEG) && (vcount < VS_END));
  assign raddr_p0  = active_p0 ? (AW'(vcount) * LINE_LEN + AW'(col)) : '0;

  // stage p1: front-buffer read
  logic [PIX_W-1:0] pix_p1;
  logic             vld_p1, hs_p1, vs_p1;

  always_ff @(posedge clk) begin
    pix_p1 <= front ? fb1[raddr_p0] : fb0[raddr_p0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
    end else begin
      vld_p1 <= active_p0;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
    end
  end

  // stage p2: output register
  logic [7:0] rgb_p2;
  logic       vld_p2, hs_p2, vs_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_p2 <= '0;
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
    end else begin
      rgb_p2 <= vld_p1 ? widen(pix_p1) : 8'd0;
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
    end
  end

  assign VGA_R       = rgb_p2;
  assign VGA_G       = rgb_p2;
  assign VGA_B       = rgb_p2;
  assign VGA_HS      = hs_p2;
  assign VGA_VS      = vs_p2;
  assign VGA_BLANK_n = vld_p2;
  assign VGA_CLK     = hcount[0];
  assign VGA_SYNC_n  = 1'b0;
endmodule

// File: tb/tb_vga_fb_display.sv
// Scoreboard bench for vga_fb_display on a shrunken 8x4 raster (line 30 clk, frame 240 clk).
module tb_vga_fb_display;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  vga_fb_display_if bus();
  logic [7:0] vr, vg, vb;
  logic       vclk, hs, vs, blank_n, sync_n;

  vga_fb_display #(
    .HACTIVE(8), .VACTIVE(4), .HFP(2), .HSW(3), .HBP(2),
    .VFP(1), .VSW(2), .VBP(1), .PIX_W(8), .AW(5)
  ) dut (
    .clk(clk), .reset(reset), .avs(bus),
    .VGA_R(vr), .VGA_G(vg), .VGA_B(vb), .VGA_CLK(vclk),
    .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_n(blank_n), .VGA_SYNC_n(sync_n)
  );

  int          checks = 0;
  int          failures = 0;
  logic [15:0] rd_q[$];
  logic [7:0]  pix_q[$];
  logic        rd_fire = 1'b0;
  logic [15:0] re;
  logic [7:0]  pe;
  logic [7:0]  img [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Read responses and pixel stream are checked here, decoupled from stimulus.
  always @(posedge clk) rd_fire <= bus.chipselect & bus.read;

  always @(negedge clk) begin
    if (rd_fire) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got 0x%0h, expected no read response", bus.readdata);
      end else begin
        re = rd_q.pop_front();
        check("readdata", 32'(bus.readdata), 32'(re));
      end
    end
    if (!blank_n)
      check("rgb_blank", 32'({vr, vg, vb}), 32'd0);
    else if (pix_q.size() != 0) begin
      pe = pix_q.pop_front();
      check("rgb_pixel", 32'({vr, vg, vb}), 32'({pe, pe, pe}));
    end
  end

  function automatic bit sigv(input int s);
    case (s)
      0:       return hs;
      1:       return vs;
      default: return blank_n;
    endcase
  endfunction

  task automatic drive(input logic c, input logic w, input logic r,
                       input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.chipselect = c;
    bus.write      = w;
    bus.read       = r;
    bus.address    = a;
    bus.writedata  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    drive(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp);
    drive(1'b1, 1'b0, 1'b1, a, 16'd0);
    rd_q.push_back(exp);
  endtask

  task automatic wait_edge(input int s, input bit lvl, input string name);
    bit prev;
    bit done;
    idle(1);
    prev = sigv(s);
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (prev != lvl && sigv(s) == lvl) done = 1'b1;
      prev = sigv(s);
    end
    if (!done) check({"timeout_", name}, 32'd0, 32'd1);
  endtask

  task automatic measure(input int s, input string name, output int per, output int low);
    bit seen_hi;
    bit done;
    wait_edge(s, 1'b0, name);
    low = 1;
    per = 0;
    seen_hi = 1'b0;
    done = 1'b0;
    for (int t = 1; t < 2000 && !done; t++) begin
      @(negedge clk);
      if (sigv(s)) seen_hi = 1'b1;
      else if (!seen_hi) low++;
      else begin
        per = t;
        done = 1'b1;
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 1000 && pix_q.size() != 0; i++) @(negedge clk);
    check("pix_drain", 32'(pix_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int per, low, t_hf, t_hr, t;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.address    = 3'd0;
    bus.writedata  = 16'd0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_hs", 32'(hs), 32'd1);
    check("rst_vs", 32'(vs), 32'd1);
    check("rst_blank", 32'(blank_n), 32'd0);
    check("rst_readdata", 32'(bus.readdata), 32'd0);
    check("sync_n", 32'(sync_n), 32'd0);
    reset = 1'b0;
    rd(3'd5, 16'h0);
    rd(3'd6, 16'h0);
    idle(1);

    // Free-running timing
    measure(0, "hs", per, low);
    check("hs_period", 32'(per), 32'd30);
    check("hs_low", 32'(low), 32'd6);
    measure(1, "vs", per, low);
    check("vs_period", 32'(per), 32'd240);
    check("vs_low", 32'(low), 32'd60);

    // HS edges relative to end of active video
    wait_edge(2, 1'b0, "blank");
    t_hf = 0;
    t_hr = 0;
    for (int i = 1; i < 100 && t_hr == 0; i++) begin
      @(negedge clk);
      if (!hs && t_hf == 0) t_hf = i;
      if (hs && t_hf != 0) t_hr = i;
    end
    check("blank_to_hs_fall", 32'(t_hf), 32'd4);
    check("blank_to_hs_rise", 32'(t_hr), 32'd10);

    // Fill 0x80 into back buffer with a swap requested during the fill
    wr(3'd4, 16'h80);
    wr(3'd3, 16'h2);
    wr(3'd3, 16'h1);
    rd(3'd5, 16'h3);
    idle(29);
    rd(3'd5, 16'h3);
    rd(3'd5, 16'h1);
    idle(1);
    wait_edge(1, 1'b1, "vs_rise_a");
    wait_edge(1, 1'b0, "vs_fall_a");
    rd(3'd6, 16'd1);
    rd(3'd5, 16'h4);
    idle(1);
    wait_edge(1, 1'b1, "vs_rise_b");
    for (int i = 0; i < 64; i++) pix_q.push_back(8'h80);
    wait_drain();

    // Fill 0x10 with interleaved pixel writes (3 writes -> 3 extra clk)
    wr(3'd4, 16'h10);
    wr(3'd0, 16'd7);
    wr(3'd1, 16'd3);
    wr(3'd3, 16'h2);
    wr(3'd2, 16'hA1);
    idle(1);
    wr(3'd2, 16'hA2);
    idle(1);
    wr(3'd2, 16'hA3);
    idle(29);
    rd(3'd5, 16'h6);
    rd(3'd5, 16'h4);

    // Pointer wrap and clamping
    wr(3'd0, 16'd6);
    wr(3'd1, 16'd1);
    wr(3'd2, 16'h11);
    wr(3'd2, 16'h22);
    wr(3'd2, 16'h33);
    wr(3'd0, 16'd700);
    wr(3'd1, 16'd0);
    wr(3'd2, 16'h44);
    wr(3'd1, 16'd900);
    wr(3'd0, 16'd2);
    wr(3'd2, 16'h55);
    wr(3'd0, 16'd5);
    wr(3'd1, 16'd0);
    wr(3'd2, 16'hFF);
    wr(3'd7, 16'hFFFF);
    wr(3'd3, 16'h1);
    idle(1);
    wait_edge(1, 1'b1, "vs_rise_c");
    wait_edge(1, 1'b0, "vs_fall_c");
    rd(3'd6, 16'd2);
    rd(3'd5, 16'h0);
    rd(3'd7, 16'h0);
    idle(1);
    for (int i = 0; i < 32; i++) img[i] = 8'h10;
    img[0]  = 8'hA2;
    img[1]  = 8'hA3;
    img[5]  = 8'hFF;
    img[7]  = 8'h44;
    img[14] = 8'h11;
    img[15] = 8'h22;
    img[16] = 8'h33;
    img[26] = 8'h55;
    wait_edge(1, 1'b1, "vs_rise_d");
    for (int i = 0; i < 32; i++) begin
      pix_q.push_back(img[i]);
      pix_q.push_back(img[i]);
    end
    wait_drain();

    // Reset in the middle of a fill
    wr(3'd3, 16'h2);
    idle(5);
    @(negedge clk);
    reset = 1'b1;
    rd(3'd5, 16'h0);
    idle(1);
    rd(3'd6, 16'h0);
    idle(3);
    check("rst2_hs", 32'(hs), 32'd1);
    check("rst2_vs", 32'(vs), 32'd1);
    check("rst2_blank", 32'(blank_n), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    t = 0;
    for (int i = 1; i < 100 && t == 0; i++) begin
      @(negedge clk);
      if (!hs) t = i;
    end
    check("rst2_first_hs_fall", 32'(t), 32'd22);
    rd(3'd5, 16'h0);
    rd(3'd6, 16'h0);
    idle(3);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
